// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: UART byte stream and memory write port bundle for the boot loader
interface uart_program_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0] rx_data;
  logic rx_valid;
  logic rx_ferr;
  logic [7:0] tx_data;
  logic tx_start;
  logic tx_busy;
  logic imem_we;
  logic dmem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic load_done;
  logic rx_error;
  modport master (
    input rx_data, rx_valid, rx_ferr, tx_busy,
    output tx_data, tx_start, imem_we, dmem_we, mem_addr, mem_wdata, load_done, rx_error
  );
  modport slave (
    output rx_data, rx_valid, rx_ferr, tx_busy,
    input tx_data, tx_start, imem_we, dmem_we, mem_addr, mem_wdata, load_done, rx_error
  );
endinterface

// File: rtl/uart_program_loader.sv
// uart_program_loader: handshakes with the host over UART and streams program/data images into memory
module uart_program_loader #(
  parameter int PROG_BYTES = 37,
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W = 10
) (
  input logic clk,
  input logic reset,
  uart_program_loader_if.master bus
);
  typedef enum logic [2:0] {SEND_RDY, TX_WAIT, RX_PROG, SEND_REQ, RX_DATA, DONE} state_t;
  localparam logic [10:0] PB = 11'(PROG_BYTES);
  localparam logic [10:0] DB = 11'(DATA_BYTES);
  state_t state, state_n, ret;
  logic first, send, rx_win, take, word_end;
  logic tx_start, imem_we, dmem_we, load_done, rx_error;
  logic [10:0] cnt, cnt_max;
  logic [ADDR_W-1:0] widx, mem_addr;
  logic [31:0] asm_w, word, mem_wdata;
  logic [7:0] tx_data;
  // byte acceptance window and little-endian merge of the incoming byte into the partial word
  always_comb begin
    rx_win = state == RX_PROG || state == RX_DATA;
    cnt_max = state == RX_PROG ? PB : DB;
    take = rx_win && bus.rx_valid && !bus.rx_ferr && cnt < cnt_max;
    word = asm_w | (32'(bus.rx_data) << {cnt[1:0], 3'b000});
    word_end = cnt[1:0] == 2'd3 || cnt + 11'd1 == cnt_max;
  end
  // next-state logic; an image phase ends once its last word's strobe is out
  always_comb begin
    state_n = state;
    send = 1'b0;
    case (state)
      SEND_RDY, SEND_REQ: if (!bus.tx_busy) begin
        send = 1'b1;
        state_n = TX_WAIT;
      end
      TX_WAIT: if (!first && !bus.tx_busy) state_n = ret;
      RX_PROG: if (imem_we && cnt == PB) state_n = DATA_BYTES == 0 ? DONE : SEND_REQ;
      RX_DATA: if (dmem_we && cnt == DB) state_n = DONE;
      default: ;
    endcase
  end
  // state register; first masks tx_busy until uart_tx has seen the start pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEND_RDY;
      ret <= RX_PROG;
      first <= 1'b0;
    end else begin
      state <= state_n;
      first <= send;
      if (send) ret <= state == SEND_RDY ? RX_PROG : RX_DATA;
    end
  end
  // tx request, word assembly, write port and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_start <= 1'b0;
      tx_data <= '0;
      imem_we <= 1'b0;
      dmem_we <= 1'b0;
      load_done <= 1'b0;
      rx_error <= 1'b0;
      cnt <= '0;
      widx <= '0;
      asm_w <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      tx_start <= send;
      if (send) tx_data <= state == SEND_RDY ? 8'h99 : 8'hAA;
      imem_we <= take && word_end && state == RX_PROG;
      dmem_we <= take && word_end && state == RX_DATA;
      load_done <= state_n == DONE;
      if (rx_win && bus.rx_valid && bus.rx_ferr) rx_error <= 1'b1;
      if (send) begin
        cnt <= '0;
        widx <= '0;
        asm_w <= '0;
      end else if (take) begin
        cnt <= cnt + 11'd1;
        asm_w <= word_end ? '0 : word;
        if (word_end) begin
          mem_wdata <= word;
          mem_addr <= widx;
          widx <= widx + 1'b1;
        end
      end
    end
  end
  assign bus.tx_start = tx_start;
  assign bus.tx_data = tx_data;
  assign bus.imem_we = imem_we;
  assign bus.dmem_we = dmem_we;
  assign bus.mem_addr = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.load_done = load_done;
  assign bus.rx_error = rx_error;
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: directed checks of the loader handshake, word assembly, errors and reset abort
module tb_uart_program_loader;
  logic clk = 0;
  logic rst_a = 1;
  logic rst_b = 1;
  always #5 clk = ~clk;

  uart_program_loader_if #(.ADDR_W(10)) ia ();
  uart_program_loader_if #(.ADDR_W(10)) ib ();
  uart_program_loader #(.PROG_BYTES(37), .DATA_BYTES(4), .ADDR_W(10)) u_a (.clk(clk), .reset(rst_a), .bus(ia));
  uart_program_loader #(.PROG_BYTES(8), .DATA_BYTES(0), .ADDR_W(10)) u_b (.clk(clk), .reset(rst_b), .bus(ib));

  typedef struct {
    logic v;
    logic [7:0] d;
    logic we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic done;
  } row_t;
  row_t rows [10];
  logic [31:0] exp_w [10] = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C, 32'h23222120,
                             32'h27262524, 32'h2B2A2928, 32'h2F2E2D2C, 32'h33323130, 32'h00000034};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [9:0] iw_addr [64];
  logic [31:0] iw_data [64];
  int iw_n = 0;
  logic [9:0] dw_addr;
  logic [31:0] dw_data;
  int dw_n = 0;
  int dw_cyc = -1;
  int ld_cyc = -1;
  int txa_n = 0;
  int txb_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ia.imem_we && iw_n < 64) begin
      iw_addr[iw_n] <= ia.mem_addr;
      iw_data[iw_n] <= ia.mem_wdata;
      iw_n <= iw_n + 1;
    end
    if (ia.dmem_we) begin
      dw_addr <= ia.mem_addr;
      dw_data <= ia.mem_wdata;
      dw_n <= dw_n + 1;
      dw_cyc <= cyc;
    end
    if (ia.load_done && ld_cyc < 0) ld_cyc <= cyc;
    if (ia.tx_start) txa_n <= txa_n + 1;
    if (ib.tx_start) txb_n <= txb_n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_a(input logic [7:0] d, input logic f);
    ia.rx_data = d;
    ia.rx_ferr = f;
    ia.rx_valid = 1'b1;
    step();
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_tx_start"}, 32'(ia.tx_start), 0);
    check({tag, "_tx_data"}, 32'(ia.tx_data), 0);
    check({tag, "_we"}, 32'({ia.imem_we, ia.dmem_we}), 0);
    check({tag, "_addr"}, 32'(ia.mem_addr), 0);
    check({tag, "_wdata"}, ia.mem_wdata, 0);
    check({tag, "_flags"}, 32'({ia.load_done, ia.rx_error}), 0);
  endtask

  initial begin
    int base;
    int t;
    rows[0] = '{1'b1, 8'h13, 1'b0, 0, 32'h0, 1'b0};
    rows[1] = '{1'b1, 8'h00, 1'b0, 0, 32'h0, 1'b0};
    rows[2] = '{1'b1, 8'h00, 1'b0, 0, 32'h0, 1'b0};
    rows[3] = '{1'b1, 8'h00, 1'b1, 0, 32'h00000013, 1'b0};
    rows[4] = '{1'b1, 8'h93, 1'b0, 0, 32'h00000013, 1'b0};
    rows[5] = '{1'b1, 8'h01, 1'b0, 0, 32'h00000013, 1'b0};
    rows[6] = '{1'b1, 8'h50, 1'b0, 0, 32'h00000013, 1'b0};
    rows[7] = '{1'b1, 8'h00, 1'b1, 1, 32'h00500193, 1'b0};
    rows[8] = '{1'b0, 8'h00, 1'b0, 1, 32'h00500193, 1'b1};
    rows[9] = '{1'b1, 8'hFF, 1'b0, 1, 32'h00500193, 1'b1};
    ia.rx_data = 0; ia.rx_valid = 0; ia.rx_ferr = 0; ia.tx_busy = 0;
    ib.rx_data = 0; ib.rx_valid = 0; ib.rx_ferr = 0; ib.tx_busy = 0;
    repeat (3) step();
    check_zero_a("reset");
    rst_a = 0;
    step();
    check("rdy_start", 32'(ia.tx_start), 1);
    check("rdy_data", 32'(ia.tx_data), 32'h99);
    ia.tx_busy = 1;
    repeat (51) step();
    check("busy_no_retx", txa_n, 1);
    ia.tx_busy = 0;
    step();
    step();
    for (int i = 0; i < 5; i++) send_a(8'h40 + 8'(i), 1'b0);
    ia.rx_valid = 0;
    step();
    step();
    check("partial_writes", iw_n, 1);
    check("partial_wdata", ia.mem_wdata, 32'h43424140);
    #2 rst_a = 1;
    #1;
    check_zero_a("abort");
    step();
    rst_a = 0;
    step();
    check("rerdy_start", 32'(ia.tx_start), 1);
    check("rerdy_data", 32'(ia.tx_data), 32'h99);
    base = iw_n;
    step();
    step();
    for (int k = 0; k < 37; k++) begin
      if (k == 2) send_a(8'hEE, 1'b1);
      send_a(8'h10 + 8'(k), 1'b0);
    end
    ia.rx_valid = 0;
    ia.rx_ferr = 0;
    t = 0;
    while (!ia.tx_start && t < 40) begin
      step();
      t++;
    end
    check("req_seen", 32'(ia.tx_start), 1);
    check("req_data", 32'(ia.tx_data), 32'hAA);
    check("rx_error_set", 32'(ia.rx_error), 1);
    check("prog_writes", iw_n - base, 10);
    for (int j = 0; j < 10; j++) begin
      check($sformatf("prog_addr%0d", j), 32'(iw_addr[base + j]), j);
      check($sformatf("prog_word%0d", j), iw_data[base + j], exp_w[j]);
    end
    step();
    step();
    send_a(8'h19, 1'b0);
    send_a(8'h00, 1'b0);
    send_a(8'h00, 1'b0);
    send_a(8'h00, 1'b0);
    ia.rx_valid = 0;
    repeat (3) step();
    check("data_writes", dw_n, 1);
    check("data_addr", 32'(dw_addr), 0);
    check("data_word", dw_data, 32'h00000019);
    check("done_latency", ld_cyc - dw_cyc, 1);
    check("done_a", 32'(ia.load_done), 1);
    send_a(8'h55, 1'b0);
    ia.rx_valid = 0;
    repeat (5) step();
    check("done_ignores_rx", dw_n + iw_n - base, 11);
    check("tx_total_a", txa_n, 3);
    rst_b = 0;
    step();
    check("b_rdy_start", 32'(ib.tx_start), 1);
    check("b_rdy_data", 32'(ib.tx_data), 32'h99);
    step();
    step();
    for (int r = 0; r < 10; r++) begin
      ib.rx_valid = rows[r].v;
      ib.rx_data = rows[r].d;
      step();
      check($sformatf("b_we_r%0d", r), 32'({ib.imem_we, ib.dmem_we}), {30'd0, rows[r].we, 1'b0});
      check($sformatf("b_addr_r%0d", r), 32'(ib.mem_addr), rows[r].addr);
      check($sformatf("b_wdata_r%0d", r), ib.mem_wdata, rows[r].wd);
      check($sformatf("b_done_r%0d", r), 32'(ib.load_done), 32'(rows[r].done));
    end
    ib.rx_valid = 0;
    repeat (10) step();
    check("b_no_req", txb_n, 1);
    check("b_no_error", 32'(ib.rx_error), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
- Boot-time loader that sits between the core's UART (uart_rx / uart_tx) and the instruction/data memories, ahead of top_pipe release.
- Signals readiness to the host with 0x99, receives the program image byte-wise and writes it to instruction memory as 32-bit words.
- Then requests the data image with 0xAA, receives it into data memory, and releases the core by asserting load_done.

Parameters:
- PROG_BYTES, 37: number of program-image bytes expected from the host (1..1023).
- DATA_BYTES, 4: number of data-image bytes expected (0..1023); 0 skips the 0xAA phase.
- ADDR_W, 10: word-address width of both memory write ports.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  received byte from uart_rx
- rx_valid  in  1  one-cycle strobe: rx_data is valid
- rx_ferr  in  1  framing error for the current rx_valid byte
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle transmit request
- tx_busy  in  1  uart_tx busy
- imem_we  out  1  instruction-memory write strobe
- dmem_we  out  1  data-memory write strobe
- mem_addr  out  ADDR_W  word address, shared by both ports
- mem_wdata  out  32  write word
- load_done  out  1  image loaded; core may leave reset
- rx_error  out  1  sticky: a framing-error byte was dropped

Behaviour:
- Reset (async, any state): all outputs 0; state=SEND_RDY; byte/word counters and assembly register cleared. Asserting reset mid-load aborts the load; after release, the sequence restarts from SEND_RDY.
- States: SEND_RDY, TX_WAIT, RX_PROG, SEND_REQ, RX_DATA, DONE.
- SEND_RDY: when tx_busy=0, drive tx_data=0x99, tx_start=1 for exactly one cycle, then go to TX_WAIT with next state RX_PROG.
- SEND_REQ: same as SEND_RDY but sends 0xAA, with next state RX_DATA.
- TX_WAIT: tx_busy is ignored on the first cycle; from then on, the block leaves when tx_busy=0. tx_start stays 0 throughout.
- RX bytes are accepted only in RX_PROG and RX_DATA. rx_valid in any other state is discarded.
- rx_valid with rx_ferr=1: byte is dropped (not counted), rx_error is set, and it stays set until reset.
- Assembly is little-endian. Byte k of a word goes to mem_wdata[8k+7:8k]; byte 0 arrives first.
- On the 4th byte of a word, or on the final byte of the image: register the word, then pulse imem_we (RX_PROG) or dmem_we (RX_DATA) for one cycle in the next cycle. mem_addr and mem_wdata are valid in the same cycle as the strobe.
- A partial final word has its unfilled upper bytes padded with 0x00.
- mem_addr starts at 0 for each image and increments by 1 after each write strobe. mem_addr and mem_wdata hold their last values when idle.
- Latency: the write strobe occurs exactly 1 cycle after the rx_valid that completes the word.
- RX_PROG leaves after the PROG_BYTES-th byte's write. If DATA_BYTES=0 it goes to DONE, otherwise to SEND_REQ.
- RX_DATA goes to DONE after the final write.
- DONE: load_done=1 (registered, asserted the cycle after the final write strobe). Further rx bytes are ignored; no tx.
- An rx_valid arriving in the same cycle as a pending write strobe must still be captured; back-to-back rx_valid on consecutive cycles is supported.
- Counters must not overflow for the parameter limits. The byte counter is 10 bits minimum.

Test Plan:
- Reset release with tx_busy=0 → tx_start pulses once with tx_data=0x99. Holding tx_busy=1 for 50 cycles after the pulse → no second tx_start.
- PROG_BYTES=8, host bytes 13 00 00 00 93 01 50 00 → imem_we at addr 0 data 0x00000013, then addr 1 data 0x00500193. Then tx_data=0xAA pulse.
- PROG_BYTES=37 → 10 imem writes. Addr 9 data = {24'h0, byte36}. Then 0xAA is sent; DATA_BYTES=4 with 19 00 00 00 → dmem_we addr 0 data 0x00000019, then load_done=1.
- Framing error on 3rd program byte → byte dropped, rx_error=1. Word completes only after 4 good bytes, with the same contents as without the bad byte.
- Assert reset after 5 program bytes, then release → outputs 0, 0x99 resent. A full image then loads at addr 0 correctly.
- DATA_BYTES=0 → no 0xAA transmitted; load_done is asserted 1 cycle after the last imem_we.
